// File: rtl/axi_xbar_clint.sv
// One-master, two-slave AXI4 router: the CLINT address window goes to m0, everything else to m1.
// AR/AW/W payloads are registered and held for the whole transaction.
module axi_xbar_clint #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_SIZE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    output logic        s_arready,
    output logic [63:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    output logic        s_rlast,
    output logic [3:0]  s_rid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    input  logic [3:0]  s_awid,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    output logic        s_awready,
    input  logic [63:0] s_wdata,
    input  logic [7:0]  s_wstrb,
    input  logic        s_wvalid,
    input  logic        s_wlast,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    output logic [3:0]  s_bid,
    input  logic        s_bready,
    output logic [31:0] m0_araddr,
    output logic        m0_arvalid,
    output logic [3:0]  m0_arid,
    output logic [7:0]  m0_arlen,
    output logic [2:0]  m0_arsize,
    output logic [1:0]  m0_arburst,
    input  logic        m0_arready,
    input  logic [63:0] m0_rdata,
    input  logic [1:0]  m0_rresp,
    input  logic        m0_rvalid,
    input  logic        m0_rlast,
    input  logic [3:0]  m0_rid,
    output logic        m0_rready,
    output logic [31:0] m0_awaddr,
    output logic        m0_awvalid,
    output logic [3:0]  m0_awid,
    output logic [7:0]  m0_awlen,
    output logic [2:0]  m0_awsize,
    output logic [1:0]  m0_awburst,
    input  logic        m0_awready,
    output logic [63:0] m0_wdata,
    output logic [7:0]  m0_wstrb,
    output logic        m0_wvalid,
    output logic        m0_wlast,
    input  logic        m0_wready,
    input  logic [1:0]  m0_bresp,
    input  logic        m0_bvalid,
    input  logic [3:0]  m0_bid,
    output logic        m0_bready,
    output logic [31:0] m1_araddr,
    output logic        m1_arvalid,
    output logic [3:0]  m1_arid,
    output logic [7:0]  m1_arlen,
    output logic [2:0]  m1_arsize,
    output logic [1:0]  m1_arburst,
    input  logic        m1_arready,
    input  logic [63:0] m1_rdata,
    input  logic [1:0]  m1_rresp,
    input  logic        m1_rvalid,
    input  logic        m1_rlast,
    input  logic [3:0]  m1_rid,
    output logic        m1_rready,
    output logic [31:0] m1_awaddr,
    output logic        m1_awvalid,
    output logic [3:0]  m1_awid,
    output logic [7:0]  m1_awlen,
    output logic [2:0]  m1_awsize,
    output logic [1:0]  m1_awburst,
    input  logic        m1_awready,
    output logic [63:0] m1_wdata,
    output logic [7:0]  m1_wstrb,
    output logic        m1_wvalid,
    output logic        m1_wlast,
    input  logic        m1_wready,
    input  logic [1:0]  m1_bresp,
    input  logic        m1_bvalid,
    input  logic [3:0]  m1_bid,
    output logic        m1_bready
);
    localparam logic [31:0] WIN_MASK = ~(CLINT_SIZE - 32'd1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

    r_state_t    r_state_q, r_state_d;
    w_state_t    w_state_q, w_state_d;
    logic [31:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [3:0]  ar_id_q, ar_id_d, aw_id_q, aw_id_d;
    logic [7:0]  ar_len_q, ar_len_d, aw_len_q, aw_len_d;
    logic [2:0]  ar_size_q, ar_size_d, aw_size_q, aw_size_d;
    logic [1:0]  ar_burst_q, ar_burst_d, aw_burst_q, aw_burst_d;
    logic [63:0] w_data_q, w_data_d;
    logic [7:0]  w_strb_q, w_strb_d;
    logic        w_last_q, w_last_d;
    logic        aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic        aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;
    logic        r_sel0, w_sel0;

    // Slave-side ids are replaced by the latched upstream id.
    logic unused_ids;
    assign unused_ids = ^{m0_rid, m1_rid, m0_bid, m1_bid};

    assign r_sel0 = ((ar_addr_q & WIN_MASK) == CLINT_BASE);
    assign w_sel0 = ((aw_addr_q & WIN_MASK) == CLINT_BASE);

    assign m0_araddr  = ar_addr_q;   assign m1_araddr  = ar_addr_q;
    assign m0_arid    = ar_id_q;     assign m1_arid    = ar_id_q;
    assign m0_arlen   = ar_len_q;    assign m1_arlen   = ar_len_q;
    assign m0_arsize  = ar_size_q;   assign m1_arsize  = ar_size_q;
    assign m0_arburst = ar_burst_q;  assign m1_arburst = ar_burst_q;
    assign m0_awaddr  = aw_addr_q;   assign m1_awaddr  = aw_addr_q;
    assign m0_awid    = aw_id_q;     assign m1_awid    = aw_id_q;
    assign m0_awlen   = aw_len_q;    assign m1_awlen   = aw_len_q;
    assign m0_awsize  = aw_size_q;   assign m1_awsize  = aw_size_q;
    assign m0_awburst = aw_burst_q;  assign m1_awburst = aw_burst_q;
    assign m0_wdata   = w_data_q;    assign m1_wdata   = w_data_q;
    assign m0_wstrb   = w_strb_q;    assign m1_wstrb   = w_strb_q;
    assign m0_wlast   = w_last_q;    assign m1_wlast   = w_last_q;

    always_comb begin
        r_state_d  = r_state_q;
        ar_addr_d  = ar_addr_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        s_arready  = 1'b0;
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        m0_rready  = 1'b0;
        m1_rready  = 1'b0;
        s_rvalid   = 1'b0;
        s_rdata    = r_sel0 ? m0_rdata : m1_rdata;
        s_rresp    = r_sel0 ? m0_rresp : m1_rresp;
        s_rlast    = r_sel0 ? m0_rlast : m1_rlast;
        s_rid      = ar_id_q;
        case (r_state_q)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) begin
                    ar_addr_d  = s_araddr;
                    ar_id_d    = s_arid;
                    ar_len_d   = s_arlen;
                    ar_size_d  = s_arsize;
                    ar_burst_d = s_arburst;
                    r_state_d  = R_ADDR;
                end
            end
            R_ADDR: begin
                m0_arvalid = r_sel0;
                m1_arvalid = !r_sel0;
                if (r_sel0 ? m0_arready : m1_arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_rvalid  = r_sel0 ? m0_rvalid : m1_rvalid;
                m0_rready = r_sel0 & s_rready;
                m1_rready = !r_sel0 & s_rready;
                if (s_rvalid && s_rready && s_rlast) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_id_d    = aw_id_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        w_last_d   = w_last_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        aw_sent_d  = aw_sent_q;
        w_sent_d   = w_sent_q;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;
        m0_wvalid  = 1'b0;
        m1_wvalid  = 1'b0;
        m0_bready  = 1'b0;
        m1_bready  = 1'b0;
        s_bvalid   = 1'b0;
        s_bresp    = w_sel0 ? m0_bresp : m1_bresp;
        s_bid      = aw_id_q;
        case (w_state_q)
            W_IDLE: begin
                s_awready = !aw_have_q;
                s_wready  = !w_have_q;
                if (s_awvalid && !aw_have_q) begin
                    aw_addr_d  = s_awaddr;
                    aw_id_d    = s_awid;
                    aw_len_d   = s_awlen;
                    aw_size_d  = s_awsize;
                    aw_burst_d = s_awburst;
                    aw_have_d  = 1'b1;
                end
                if (s_wvalid && !w_have_q) begin
                    w_data_d = s_wdata;
                    w_strb_d = s_wstrb;
                    w_last_d = s_wlast;
                    w_have_d = 1'b1;
                end
                if (aw_have_d && w_have_d) w_state_d = W_REQ;
            end
            W_REQ: begin
                // Both valids rise together on entry, as CLINT wants AW and W in one cycle.
                m0_awvalid = w_sel0 & !aw_sent_q;
                m1_awvalid = !w_sel0 & !aw_sent_q;
                m0_wvalid  = w_sel0 & !w_sent_q;
                m1_wvalid  = !w_sel0 & !w_sent_q;
                if (!aw_sent_q && (w_sel0 ? m0_awready : m1_awready)) aw_sent_d = 1'b1;
                if (!w_sent_q && (w_sel0 ? m0_wready : m1_wready)) w_sent_d = 1'b1;
                if (aw_sent_d && w_sent_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_bvalid  = w_sel0 ? m0_bvalid : m1_bvalid;
                m0_bready = w_sel0 & s_bready;
                m1_bready = !w_sel0 & s_bready;
                if (s_bvalid && s_bready) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    aw_sent_d = 1'b0;
                    w_sent_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            w_last_q   <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_sent_q  <= 1'b0;
            w_sent_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_id_q    <= ar_id_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            aw_addr_q  <= aw_addr_d;
            aw_id_q    <= aw_id_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            w_last_q   <= w_last_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            aw_sent_q  <= aw_sent_d;
            w_sent_q   <= w_sent_d;
        end
    end

    // Writes are single-beat; anything else is forwarded but flagged in simulation.
    always_ff @(posedge clk) begin
        if (rst && s_awvalid && s_awready)
            assert (s_awlen == 8'd0) else $error("axi_xbar_clint: multi-beat write awlen=%0d", s_awlen);
        if (rst && s_wvalid && s_wready)
            assert (s_wlast) else $error("axi_xbar_clint: write beat without wlast");
    end
endmodule

// File: tb/tb_axi_xbar_clint.sv
// Directed bench for axi_xbar_clint: drives both the upstream master and the two slaves by hand.
module tb_axi_xbar_clint;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_araddr;  logic s_arvalid; logic [3:0] s_arid; logic [7:0] s_arlen;
    logic [2:0]  s_arsize;  logic [1:0] s_arburst; logic s_arready;
    logic [63:0] s_rdata;   logic [1:0] s_rresp; logic s_rvalid, s_rlast; logic [3:0] s_rid; logic s_rready;
    logic [31:0] s_awaddr;  logic s_awvalid; logic [3:0] s_awid; logic [7:0] s_awlen;
    logic [2:0]  s_awsize;  logic [1:0] s_awburst; logic s_awready;
    logic [63:0] s_wdata;   logic [7:0] s_wstrb; logic s_wvalid, s_wlast, s_wready;
    logic [1:0]  s_bresp;   logic s_bvalid; logic [3:0] s_bid; logic s_bready;
    logic [31:0] m0_araddr, m1_araddr; logic m0_arvalid, m1_arvalid;
    logic [3:0]  m0_arid, m1_arid; logic [7:0] m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize; logic [1:0] m0_arburst, m1_arburst;
    logic        m0_arready, m1_arready;
    logic [63:0] m0_rdata, m1_rdata; logic [1:0] m0_rresp, m1_rresp;
    logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast; logic [3:0] m0_rid, m1_rid;
    logic        m0_rready, m1_rready;
    logic [31:0] m0_awaddr, m1_awaddr; logic m0_awvalid, m1_awvalid;
    logic [3:0]  m0_awid, m1_awid; logic [7:0] m0_awlen, m1_awlen;
    logic [2:0]  m0_awsize, m1_awsize; logic [1:0] m0_awburst, m1_awburst;
    logic        m0_awready, m1_awready;
    logic [63:0] m0_wdata, m1_wdata; logic [7:0] m0_wstrb, m1_wstrb;
    logic        m0_wvalid, m1_wvalid, m0_wlast, m1_wlast, m0_wready, m1_wready;
    logic [1:0]  m0_bresp, m1_bresp; logic m0_bvalid, m1_bvalid; logic [3:0] m0_bid, m1_bid;
    logic        m0_bready, m1_bready;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    axi_xbar_clint dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bid(s_bid),
        .s_bready(s_bready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m0_rid(m0_rid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
        .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wlast(m0_wlast),
        .m0_wready(m0_wready), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bid(m0_bid),
        .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
        .m1_rid(m1_rid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wlast(m1_wlast),
        .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bid(m1_bid),
        .m1_bready(m1_bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_slaves();
        m0_arready = 0; m1_arready = 0; m0_rvalid = 0; m1_rvalid = 0;
        m0_rlast = 0; m1_rlast = 0; m0_rdata = '0; m1_rdata = '0;
        m0_rresp = 0; m1_rresp = 0; m0_rid = 0; m1_rid = 0;
        m0_awready = 0; m1_awready = 0; m0_wready = 0; m1_wready = 0;
        m0_bvalid = 0; m1_bvalid = 0; m0_bresp = 0; m1_bresp = 0; m0_bid = 0; m1_bid = 0;
    endtask

    // AR handshake upstream, then one AR handshake on the expected slave port.
    task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic sel0);
        @(negedge clk);
        s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = 3'd3; s_arburst = 2'b01;
        s_arvalid = 1;
        #1;
        chk("arready_idle", s_arready, 1'b1);
        chk("no_arvalid_before", m0_arvalid | m1_arvalid, 1'b0);
        @(negedge clk);
        s_arvalid = 0;
        #1;
        chk("m0_arvalid", m0_arvalid, sel0);
        chk("m1_arvalid", m1_arvalid, !sel0);
        chk("araddr", sel0 ? m0_araddr : m1_araddr, addr);
        chk("arid_fwd", sel0 ? m0_arid : m1_arid, id);
        chk("arready_busy", s_arready, 1'b0);
        if (sel0) m0_arready = 1; else m1_arready = 1;
        @(negedge clk);
        m0_arready = 0; m1_arready = 0;
    endtask

    // Single beat read, issued and completed.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic sel0,
                           input logic [63:0] data, input logic [1:0] resp);
        ar_issue(addr, id, 8'd0, sel0);
        if (sel0) begin
            m0_rvalid = 1; m0_rdata = data; m0_rresp = resp; m0_rlast = 1; m0_rid = 4'd0;
        end else begin
            m1_rvalid = 1; m1_rdata = data; m1_rresp = resp; m1_rlast = 1; m1_rid = 4'd9;
        end
        s_rready = 1;
        #1;
        chk("rvalid", s_rvalid, 1'b1);
        chk("rdata", s_rdata, data);
        chk("rresp", s_rresp, resp);
        chk("rid", s_rid, id);
        chk("rready_sel", {m0_rready, m1_rready}, {sel0, !sel0});
        @(negedge clk);
        clear_slaves(); s_rready = 0;
        #1;
        chk("r_back_idle", s_arready, 1'b1);
        $display("read addr=%h id=%0d sel0=%0d done", addr, id, sel0);
    endtask

    initial begin
        logic [7:0]  stall_pat;
        logic [63:0] beat_data;
        int          beat;
        int          cycles;

        rst = 0;
        s_arvalid = 0; s_araddr = '0; s_arid = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
        s_rready = 0; s_awvalid = 0; s_awaddr = '0; s_awid = 0; s_awlen = 0; s_awsize = 0;
        s_awburst = 0; s_wvalid = 0; s_wdata = '0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
        clear_slaves();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", s_arready, 1'b1);
        chk("rst_awready", s_awready, 1'b1);
        chk("rst_wready", s_wready, 1'b1);
        chk("rst_rvalid", s_rvalid, 1'b0);
        chk("rst_bvalid", s_bvalid, 1'b0);
        chk("rst_mvalids", {m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid}, 6'd0);
        chk("rst_mreadies", {m0_rready, m1_rready, m0_bready, m1_bready}, 4'd0);
        rst = 1;

        // CLINT read with a stalled first R cycle; address must stay put until the R handshake.
        ar_issue(32'h0200_0000, 4'd3, 8'd0, 1'b1);
        m0_rvalid = 1; m0_rdata = 64'h1122_3344_5566_7788; m0_rlast = 1; m0_rid = 4'd0;
        s_rready = 0;
        #1;
        chk("clint_rvalid", s_rvalid, 1'b1);
        chk("clint_rready_stall", m0_rready, 1'b0);
        chk("clint_rid", s_rid, 4'd3);
        chk("clint_araddr_hold", m0_araddr, 32'h0200_0000);
        chk("clint_m1_idle", {m1_arvalid, m1_rready}, 2'b00);
        @(negedge clk);
        s_rready = 1;
        #1;
        chk("clint_rready", m0_rready, 1'b1);
        chk("clint_rdata", s_rdata, 64'h1122_3344_5566_7788);
        chk("clint_araddr_last", m0_araddr, 32'h0200_0000);
        @(negedge clk);
        clear_slaves(); s_rready = 0;
        #1;
        chk("clint_idle", s_arready, 1'b1);
        $display("read clint id=3 done");

        // Four-beat burst to memory under a fixed stall pattern.
        ar_issue(32'h8000_0000, 4'd6, 8'd3, 1'b0);
        stall_pat = 8'b1101_0110;
        beat = 0;
        cycles = 0;
        while (beat < 4 && cycles < 40) begin
            beat_data = 64'hA5A5_0000_0000_0000 + 64'(beat);
            m1_rvalid = 1; m1_rdata = beat_data; m1_rlast = (beat == 3); m1_rid = 4'd1;
            s_rready = stall_pat[cycles % 8];
            #1;
            chk("burst_rdata", s_rdata, beat_data);
            chk("burst_rready", m1_rready, s_rready);
            chk("burst_rlast", s_rlast, (beat == 3));
            chk("burst_m0_quiet", m0_rready, 1'b0);
            if (s_rready) begin
                $display("burst beat %0d data=%h", beat, s_rdata);
                beat++;
            end
            cycles++;
            @(negedge clk);
        end
        chk("burst_beats", beat, 4);
        clear_slaves(); s_rready = 0;
        #1;
        chk("burst_idle", s_arready, 1'b1);

        // CLINT write with W presented two cycles ahead of AW.
        @(negedge clk);
        s_wvalid = 1; s_wdata = 64'hDEAD_BEEF_0000_0001; s_wstrb = 8'h0F; s_wlast = 1;
        #1;
        chk("w_wready", s_wready, 1'b1);
        @(negedge clk);
        s_wvalid = 0;
        #1;
        chk("w_held_wready", s_wready, 1'b0);
        chk("w_held_awready", s_awready, 1'b1);
        chk("w_no_early_valid", m0_awvalid | m0_wvalid, 1'b0);
        @(negedge clk);
        s_awvalid = 1; s_awaddr = 32'h0200_0004; s_awid = 4'd5; s_awlen = 0;
        s_awsize = 3'd3; s_awburst = 2'b01;
        #1;
        chk("aw_awready", s_awready, 1'b1);
        @(negedge clk);
        s_awvalid = 0;
        #1;
        chk("w_both_valid", {m0_awvalid, m0_wvalid}, 2'b11);
        chk("w_m1_quiet", {m1_awvalid, m1_wvalid}, 2'b00);
        chk("w_awaddr", m0_awaddr, 32'h0200_0004);
        chk("w_wdata", m0_wdata, 64'hDEAD_BEEF_0000_0001);
        chk("w_wstrb", m0_wstrb, 8'h0F);
        m0_awready = 1; m0_wready = 1;
        @(negedge clk);
        m0_awready = 0; m0_wready = 0;
        #1;
        chk("w_valids_drop", {m0_awvalid, m0_wvalid}, 2'b00);
        m0_bvalid = 1; m0_bresp = 2'b10; m0_bid = 4'd0; s_bready = 1;
        #1;
        chk("w_bvalid", s_bvalid, 1'b1);
        chk("w_bresp", s_bresp, 2'b10);
        chk("w_bid", s_bid, 4'd5);
        chk("w_bready", {m0_bready, m1_bready}, 2'b10);
        @(negedge clk);
        clear_slaves(); s_bready = 0;
        #1;
        chk("w_idle", {s_awready, s_wready, s_bvalid}, 3'b110);
        $display("write clint addr=02000004 id=5 bresp=2 done");

        // Window boundaries.
        do_read(32'h0200_FFFC, 4'd1, 1'b1, 64'h0000_0000_CAFE_0001, 2'b00);
        do_read(32'h0201_0000, 4'd2, 1'b0, 64'h0000_0000_CAFE_0002, 2'b11);
        do_read(32'h01FF_FFFC, 4'd4, 1'b0, 64'h0000_0000_CAFE_0003, 2'b01);

        // Concurrent CLINT read and memory write issued in one cycle.
        @(negedge clk);
        s_arvalid = 1; s_araddr = 32'h0200_0008; s_arid = 4'd1; s_arlen = 0;
        s_awvalid = 1; s_awaddr = 32'h8000_0000; s_awid = 4'd2; s_awlen = 0;
        s_wvalid = 1; s_wdata = 64'h0123_4567_89AB_CDEF; s_wstrb = 8'hFF; s_wlast = 1;
        @(negedge clk);
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
        #1;
        chk("cc_valids", {m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid},
            6'b10_01_01);
        chk("cc_wdata", m1_wdata, 64'h0123_4567_89AB_CDEF);
        m0_arready = 1; m1_awready = 1; m1_wready = 1;
        @(negedge clk);
        clear_slaves();
        m0_rvalid = 1; m0_rdata = 64'h0000_0000_0000_0042; m0_rlast = 1;
        m1_bvalid = 1; m1_bresp = 2'b00; m1_bid = 4'd7;
        s_rready = 1; s_bready = 1;
        #1;
        chk("cc_quiet", {m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid}, 6'd0);
        chk("cc_rdata", s_rdata, 64'h0000_0000_0000_0042);
        chk("cc_rid", s_rid, 4'd1);
        chk("cc_bvalid", s_bvalid, 1'b1);
        chk("cc_bid", s_bid, 4'd2);
        chk("cc_readies", {m0_rready, m1_rready, m0_bready, m1_bready}, 4'b1001);
        @(negedge clk);
        clear_slaves(); s_rready = 0; s_bready = 0;
        #1;
        chk("cc_idle", {s_arready, s_awready, s_wready}, 3'b111);
        $display("concurrent read clint / write mem done");

        // Reset while a CLINT beat is pending.
        ar_issue(32'h0200_0010, 4'd8, 8'd0, 1'b1);
        m0_rvalid = 1; m0_rlast = 1; m0_rdata = 64'h5555; s_rready = 0;
        rst = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_arready", s_arready, 1'b1);
        chk("mid_rst_rvalid", s_rvalid, 1'b0);
        chk("mid_rst_rready", m0_rready, 1'b0);
        clear_slaves();
        $display("reset during R_DATA done");
        do_read(32'h0200_0018, 4'd9, 1'b1, 64'h7777_8888_9999_AAAA, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
